uart_rx: RTL

Serial-to-parallel UART receiver for the 8N1 link. It samples the asynchronous `rx` line in the system clock domain and reassembles each frame into a byte. It presents the byte with a one-cycle `valid` strobe to the downstream consumer logic, such as the arithmetic stage under test. It is the front end of the UART datapath and the counterpart of the transmitter.

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/uart_rx_if.sv | 20 ++
 rtl/uart_rx_sync2.sv | 26 ++
 rtl/uart_rx.sv | 139 +++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encodings and 8N1 frame constants.
package uart_rx_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// UART receiver bus: serial line in, received byte and status strobes out.
//   rx        : asynchronous serial line, idles high
//   data      : last correctly received byte
//   valid     : one-cycle strobe marking a new data value
//   frame_err : one-cycle strobe marking a bad stop bit
//   busy      : receiver is inside a frame or waiting out a break
interface uart_rx_if;
    import uart_rx_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 busy;

    // master: the receiver; slave: line driver / byte consumer
    modport master (input rx, output data, output valid, output frame_err, output busy);
    modport slave  (output rx, input data, input valid, input frame_err, input busy);

endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output, RESET_VAL while in reset
module uart_rx_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, samples each bit at its centre and
// reassembles bytes, reporting good frames with valid and bad stop bits with
// frame_err.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : uart_rx_if master (rx in; data, valid, frame_err, busy out)
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    uart_rx_if.master  bus
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF_LAST    = CLKS_PER_BIT / 2 - 1;
    localparam int unsigned FULL_LAST    = CLKS_PER_BIT - 1;

    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
        $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end

    logic                 rx_s;
    uart_state_t          state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [BIT_IDX_W-1:0] bit_idx, bit_idx_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic [DATA_BITS-1:0] data_q, data_nxt;
    logic                 valid_q, valid_nxt;
    logic                 ferr_q, ferr_nxt;
    logic                 busy_q, busy_nxt;

    // Line synchronizer; resets to the idle level so reset never looks like a start bit
    uart_rx_sync2 #(
        .RESET_VAL (LINE_IDLE)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.rx),
        .q   (rx_s)
    );

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            ferr_q  <= ferr_nxt;
            busy_q  <= busy_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CNT_W'(1);
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        data_nxt    = data_q;
        valid_nxt   = 1'b0;
        ferr_nxt    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                cnt_nxt     = '0;
                bit_idx_nxt = '0;
                if (rx_s == START_BIT) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                // Half-bit check rejects glitches shorter than the start bit centre
                if (cnt == CNT_W'(HALF_LAST)) begin
                    state_nxt = (rx_s == START_BIT) ? ST_DATA : ST_IDLE;
                end
            end
            ST_DATA: begin
                if (cnt == CNT_W'(FULL_LAST)) begin
                    cnt_nxt     = '0;
                    shift_nxt   = {rx_s, shift[DATA_BITS-1:1]};
                    bit_idx_nxt = bit_idx + BIT_IDX_W'(1);
                    if (bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
                        state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt == CNT_W'(FULL_LAST)) begin
                    if (rx_s == STOP_BIT) begin
                        data_nxt  = shift;
                        valid_nxt = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Hold off until the line recovers so a stuck-low line is not decoded as 0x00s
                cnt_nxt = '0;
                if (rx_s == LINE_IDLE) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (state_nxt != state) begin
            cnt_nxt = '0;
        end

        busy_nxt = (state_nxt != ST_IDLE);
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = busy_q;

endmodule
